// File: rtl/snn_pkg.sv
// Shared SNN constants and the image loader state encoding.
// Used by the loader, its bitmap RAM and the core.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_ADDR_W = 10;
  localparam int NUM_BYTES  = NUM_PIXELS / 8;

  localparam logic [PIX_ADDR_W-1:0] LAST_PIX =
    PIX_ADDR_W'(NUM_BYTES * 8 - 1);
  localparam logic [PIX_ADDR_W-1:0] PIX_END =
    PIX_ADDR_W'(NUM_PIXELS);

  typedef enum logic [1:0] {
    LOAD,
    UNPACK,
    START,
    RUN
  } ld_state_t;

endpackage

// File: rtl/snn_image_loader_if.sv
// UART receiver to image loader byte handshake.
// The receiver holds rx_rdy until the loader pulses clr_rx_rdy.
interface snn_image_loader_if;

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;

  modport master (
    output rx_rdy,
    output rx_data,
    input  clr_rx_rdy
  );

  modport slave (
    input  rx_rdy,
    input  rx_data,
    output clr_rx_rdy
  );

endinterface

// File: rtl/input_bitmap_ram.sv
// 784x1 bitmap: one write port, independent registered read port.
// Reads past the last pixel return 0; same-address write/read gives old data.
module input_bitmap_ram
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [PIX_ADDR_W-1:0] i_waddr,
  input  logic                  i_wdata,
  input  logic [PIX_ADDR_W-1:0] i_raddr,
  output logic                  o_q
);

  logic r_mem [NUM_PIXELS];
  logic r_q;
  logic w_in_range;

  assign w_in_range = (i_raddr < PIX_END);
  assign o_q = r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_in_range ? r_mem[i_raddr] : 1'b0;
    end
  end

endmodule

// File: rtl/snn_image_loader.sv
// Unpacks UART bytes LSB-first into the input bitmap, starts the core,
// serves pixel reads and latches the classification result.
module snn_image_loader
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  snn_image_loader_if.slave     rx,
  input  logic [PIX_ADDR_W-1:0] addr_input_unit,
  output logic                  q_input,
  output logic                  start,
  input  logic                  done,
  input  logic [3:0]            digit,
  output logic [3:0]            result,
  output logic                  result_vld,
  output logic                  busy,
  output logic                  overrun
);

  ld_state_t             r_state;
  logic [PIX_ADDR_W-1:0] r_pix_cnt;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shreg;
  logic                  r_clr_rx_rdy;
  logic                  r_start;
  logic [3:0]            r_result;
  logic                  r_result_vld;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  w_we;
  logic                  w_rx_new;

  assign rx.clr_rx_rdy = r_clr_rx_rdy;
  assign start         = r_start;
  assign result        = r_result;
  assign result_vld    = r_result_vld;
  assign busy          = r_busy;
  assign overrun       = r_overrun;

  // rx_rdy is still high while our clear pulse is out; not a new byte
  assign w_rx_new = rx.rx_rdy && !r_clr_rx_rdy;
  assign w_we     = (r_state == UNPACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_pix_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_start      <= 1'b0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_clr_rx_rdy <= 1'b0;
      r_start      <= 1'b0;
      r_result_vld <= 1'b0;
      unique case (r_state)
        LOAD: begin
          if (w_rx_new) begin
            r_shreg      <= rx.rx_data;
            r_clr_rx_rdy <= 1'b1;
            r_overrun    <= 1'b0;
            r_bit_cnt    <= '0;
            r_state      <= UNPACK;
          end
        end
        UNPACK: begin
          r_shreg   <= r_shreg >> 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_pix_cnt != LAST_PIX) begin
            r_pix_cnt <= r_pix_cnt + PIX_ADDR_W'(1);
          end
          if (r_bit_cnt == 3'd7) begin
            r_state <= (r_pix_cnt == LAST_PIX) ? START : LOAD;
          end
        end
        START: begin
          r_start   <= 1'b1;
          r_busy    <= 1'b1;
          r_pix_cnt <= '0;
          r_state   <= RUN;
        end
        RUN: begin
          if (w_rx_new) begin
            r_clr_rx_rdy <= 1'b1;
            r_overrun    <= 1'b1;
          end
          if (done) begin
            r_result     <= digit;
            r_result_vld <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= LOAD;
          end
        end
      endcase
    end
  end

  input_bitmap_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_pix_cnt),
    .i_wdata (r_shreg[0]),
    .i_raddr (addr_input_unit),
    .o_q     (q_input)
  );

  a_pix_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    r_pix_cnt <= LAST_PIX
  );

endmodule
